// File: rtl/reg_file_dumper.sv
// Debug read-out engine: walks the register file a pair at a time and streams each word over valid/ready.
// Optional checksum word: define DUMP_CHECKSUM_EN to append a running XOR after the last register.
module reg_file_dumper #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [4:0]        rf_adr1,
  output logic [4:0]        rf_adr2,
  input  logic [DATA_W-1:0] rf_rs1,
  input  logic [DATA_W-1:0] rf_rs2,
  output logic [DATA_W-1:0] dump_data,
  output logic [4:0]        dump_idx,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic [2:0]        o_dbg_state
);

  // Handshake: a word transfers on a posedge where dump_valid and dump_ready are both high;
  // once dump_valid rises, it and dump_data/dump_idx/dump_last hold until that transfer.

  localparam logic [3:0] LAST_P = 4'(NUM_REGS / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND0 = 3'd2,
    S_SEND1 = 3'd3,
`ifdef DUMP_CHECKSUM_EN
    S_CKSUM = 3'd4,
`endif
    S_FIN   = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_ptr;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic              w_fire;
  logic              w_last_pair;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_xor;
`endif

  assign w_fire      = dump_valid & dump_ready;
  assign w_last_pair = (r_ptr == LAST_P);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_buf0  <= '0;
      r_buf1  <= '0;
`ifdef DUMP_CHECKSUM_EN
      r_xor   <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_xor <= '0;
`endif
          end
        end
        S_FETCH: begin
          // Both words land on the same edge so the pair is a consistent snapshot.
          r_buf0 <= rf_rs1;
          r_buf1 <= rf_rs2;
        end
        S_SEND0: begin
`ifdef DUMP_CHECKSUM_EN
          if (dump_ready) r_xor <= r_xor ^ r_buf0;
`endif
        end
        S_SEND1: begin
`ifdef DUMP_CHECKSUM_EN
          if (dump_ready) r_xor <= r_xor ^ r_buf1;
`endif
          if (dump_ready && !w_last_pair) r_ptr <= r_ptr + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    rf_adr1    = {r_ptr, 1'b0};
    rf_adr2    = {r_ptr, 1'b1};
    dump_data  = '0;
    dump_idx   = '0;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        rf_adr1 = '0;
        rf_adr2 = '0;
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        w_next = S_SEND0;
      end
      S_SEND0: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        dump_data  = r_buf0;
        dump_idx   = {r_ptr, 1'b0};
        if (dump_ready) w_next = S_SEND1;
      end
      S_SEND1: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        dump_data  = r_buf1;
        dump_idx   = {r_ptr, 1'b1};
`ifdef DUMP_CHECKSUM_EN
        if (w_fire) w_next = w_last_pair ? S_CKSUM : S_FETCH;
`else
        dump_last  = w_last_pair;
        if (w_fire) w_next = w_last_pair ? S_FIN : S_FETCH;
`endif
      end
`ifdef DUMP_CHECKSUM_EN
      S_CKSUM: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        dump_data  = r_xor;
        dump_idx   = '0;
        dump_last  = 1'b1;
        if (w_fire) w_next = S_FIN;
      end
`endif
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule
